fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one FIFO write port among
//            NUM_REQ valid/ready requesters in the write clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_we,
    output logic [WIDTH-1:0]         o_fifo_wdata,
    output logic [IDW-1:0]           o_grant_id,
    output logic                     o_busy
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic [BW-1:0]    r_beat_cnt;
    logic             r_busy;

    logic [WIDTH-1:0] w_req_data [NUM_REQ];
    logic [IDW-1:0]   w_sel_id;
    logic             w_any_valid;
    logic [IDW-1:0]   w_next_rr;
    logic             w_grant_valid;
    logic             w_accept_ok;
    logic             w_xfer;
    logic             w_last_beat;

    // (base + off) mod NUM_REQ, with base < NUM_REQ and off < NUM_REQ
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDW'(sum);
    endfunction

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_req_data[k] = i_req_data[k*WIDTH +: WIDTH];
    end

    // Scan downward so the smallest offset from rr_ptr is the final winner.
    always_comb begin
        w_sel_id    = '0;
        w_any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[wrap_idx(r_rr_ptr, i)]) begin
                w_sel_id    = wrap_idx(r_rr_ptr, i);
                w_any_valid = 1'b1;
            end
        end
    end

    assign w_next_rr     = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDW'(1);
    assign w_grant_valid = i_req_valid[r_grant_id];
    // Reset blocks the handshake so a word offered in the reset cycle is never lost.
    assign w_accept_ok   = (r_state == S_BURST) && !i_fifo_full && !i_reset;
    assign w_xfer        = w_grant_valid && w_accept_ok;
    assign w_last_beat   = (r_beat_cnt == BW'(MAX_BURST - 1));

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_ready
        assign o_req_ready[k] = w_accept_ok && (r_grant_id == IDW'(k));
    end

    assign o_fifo_we    = w_xfer;
    assign o_fifo_wdata = (r_state == S_BURST) ? w_req_data[r_grant_id] : '0;
    assign o_grant_id   = r_grant_id;
    assign o_busy       = r_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id <= w_sel_id;
                        r_beat_cnt <= '0;
                        r_state    <= S_BURST;
                        r_busy     <= 1'b1;
                    end
                end
                S_BURST: begin
                    // Full stalls the burst indefinitely; only a dropped valid or the last beat ends it.
                    if (!w_grant_valid || (w_xfer && w_last_beat)) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_rr;
                    end
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Scoreboard bench for fifo_wr_arbiter with a FIFO occupancy model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;
    localparam int DEPTH     = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_we;
    logic [WIDTH-1:0]         fifo_wdata;
    logic [IDW-1:0]           grant_id;
    logic                     busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .i_fifo_full  (fifo_full),
        .o_fifo_we    (fifo_we),
        .o_fifo_wdata (fifo_wdata),
        .o_grant_id   (grant_id),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        int cyc;
    } wr_t;

    logic [WIDTH-1:0] src   [NUM_REQ][$];
    logic [WIDTH-1:0] exp_q [NUM_REQ][$];
    wr_t              wlog[$];
    bit               en [NUM_REQ];
    bit               full_force;
    bit               use_model;
    int               occ;
    int               cyc;
    int               checks;
    int               failures;

    logic                 s_we;
    logic [NUM_REQ-1:0]   s_ready;
    logic [IDW-1:0]       s_grant;
    logic                 s_busy;

    function automatic bit any_src();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (src[k].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: drive at posedge+1, sample/score at negedge.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] gmask;
        logic [WIDTH-1:0]   exp_w;
        int                 rd;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_valid[k] = en[k] && (src[k].size() > 0);
            req_data[k*WIDTH +: WIDTH] = (src[k].size() > 0) ? src[k][0] : '0;
        end
        fifo_full = use_model ? (occ >= DEPTH) : full_force;
        @(negedge clk);
        s_we    = fifo_we;
        s_ready = req_ready;
        s_grant = grant_id;
        s_busy  = busy;
        acc     = req_valid & req_ready;
        gmask   = '0;
        gmask[grant_id] = 1'b1;

        checks++;
        if (fifo_we !== (|acc)) begin
            failures++;
            $display("FAIL we_vs_handshake: we=%b valid&ready=%b cyc=%0d", fifo_we, acc, cyc);
        end
        checks++;
        if (fifo_full && fifo_we) begin
            failures++;
            $display("FAIL write_while_full: we=%b full=%b required we=0 cyc=%0d", fifo_we, fifo_full, cyc);
        end
        checks++;
        if ((req_ready & ~gmask) !== '0) begin
            failures++;
            $display("FAIL ready_onehot: ready=%b grant=%0d cyc=%0d", req_ready, grant_id, cyc);
        end
        if (!busy) begin
            checks++;
            if (fifo_wdata !== '0 || req_ready !== '0) begin
                failures++;
                $display("FAIL idle_outputs: wdata=%h ready=%b required 0/0 cyc=%0d", fifo_wdata, req_ready, cyc);
            end
        end
        if (fifo_we === 1'b1) begin
            checks++;
            if (exp_q[grant_id].size() == 0) begin
                failures++;
                $display("FAIL spurious_write: grant=%0d wdata=%h no word expected cyc=%0d", grant_id, fifo_wdata, cyc);
            end else begin
                exp_w = exp_q[grant_id].pop_front();
                if (fifo_wdata !== exp_w) begin
                    failures++;
                    $display("FAIL wdata: got=%h required=%h grant=%0d cyc=%0d", fifo_wdata, exp_w, grant_id, cyc);
                end
            end
            wlog.push_back('{int'(grant_id), int'(fifo_wdata), cyc});
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acc[k]) void'(src[k].pop_front());
        end
        if (use_model) begin
            rd  = (occ > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
            occ = occ + (fifo_we ? 1 : 0) - rd;
            checks++;
            if (occ > DEPTH) begin
                failures++;
                $display("FAIL fifo_overflow: occupancy=%0d max=%0d cyc=%0d", occ, DEPTH, cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_bench();
        for (int k = 0; k < NUM_REQ; k++) begin
            src[k].delete();
            exp_q[k].delete();
            en[k] = 1'b0;
        end
        wlog.delete();
        full_force = 1'b0;
        use_model  = 1'b0;
        occ        = 0;
    endtask

    task automatic do_reset();
        clear_bench();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load(input int k, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            src[k].push_back(WIDTH'(first + i));
            exp_q[k].push_back(WIDTH'(first + i));
        end
        en[k] = 1'b1;
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n = 0;
        while (any_src() && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (n >= bound) begin
            failures++;
            $display("FAIL %s_timeout: words still pending after %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready !== '0 || fifo_we !== 1'b0 || fifo_wdata !== '0) begin
            failures++;
            $display("FAIL reset_datapath: ready=%b we=%b wdata=%h required 0", req_ready, fifo_we, fifo_wdata);
        end
        checks++;
        if (grant_id !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%0d busy=%b required 0/0", grant_id, busy);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (s_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: busy=%b required 0", s_busy);
        end
    endtask

    task automatic test_single_stream();
        int offs [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
        int t0;
        do_reset();
        load(0, 0, 10);
        t0 = cyc;
        wait_drain(60, "single");
        step();
        step();
        checks++;
        if (wlog.size() != 10) begin
            failures++;
            $display("FAIL single_count: writes=%0d required 10", wlog.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (wlog[i].data != i || wlog[i].id != 0 || wlog[i].cyc - t0 != offs[i]) begin
                    failures++;
                    $display("FAIL single_beat%0d: data=%0d id=%0d cyc_off=%0d required %0d/0/%0d",
                             i, wlog[i].data, wlog[i].id, wlog[i].cyc - t0, i, offs[i]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int t0;
        int b;
        int exp_d;
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) load(k, k * 16, 8);
        t0 = cyc;
        wait_drain(100, "fair");
        step();
        checks++;
        if (wlog.size() != 32) begin
            failures++;
            $display("FAIL fair_count: writes=%0d required 32", wlog.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                b     = i / 4;
                exp_d = (b % 4) * 16 + (b / 4) * 4 + (i % 4);
                checks++;
                if (wlog[i].id != b % 4 || wlog[i].data != exp_d) begin
                    failures++;
                    $display("FAIL fair_order%0d: id=%0d data=%0d required %0d/%0d",
                             i, wlog[i].id, wlog[i].data, b % 4, exp_d);
                end
            end
            checks++;
            if (wlog[0].cyc - t0 != 1 || wlog[31].cyc - wlog[0].cyc != 38) begin
                failures++;
                $display("FAIL fair_throughput: first_off=%0d span=%0d required 1/38",
                         wlog[0].cyc - t0, wlog[31].cyc - wlog[0].cyc);
            end
        end
    endtask

    task automatic test_full_midburst();
        int n;
        int n0;
        do_reset();
        load(1, 'hA0, 4);
        n = 0;
        while (wlog.size() < 2 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (wlog.size() != 2) begin
            failures++;
            $display("FAIL full_pre: writes=%0d required 2", wlog.size());
        end
        full_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (s_we !== 1'b0 || s_ready !== '0 || s_grant !== IDW'(1) || s_busy !== 1'b1) begin
                failures++;
                $display("FAIL full_hold%0d: we=%b ready=%b grant=%0d busy=%b required 0/0/1/1",
                         i, s_we, s_ready, s_grant, s_busy);
            end
        end
        full_force = 1'b0;
        n0 = wlog.size();
        wait_drain(20, "full");
        checks++;
        if (wlog.size() - n0 != 2) begin
            failures++;
            $display("FAIL full_resume: writes_after=%0d required 2", wlog.size() - n0);
        end
        step();
        checks++;
        if (s_busy !== 1'b0) begin
            failures++;
            $display("FAIL full_end_idle: busy=%b required 0", s_busy);
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        load(2, 'h21, 1);
        load(3, 'h31, 2);
        wait_drain(30, "drop");
        step();
        checks++;
        if (wlog.size() != 3) begin
            failures++;
            $display("FAIL drop_count: writes=%0d required 3", wlog.size());
        end else begin
            checks++;
            if (wlog[0].id != 2 || wlog[1].id != 3 || wlog[2].id != 3) begin
                failures++;
                $display("FAIL drop_ids: %0d,%0d,%0d required 2,3,3", wlog[0].id, wlog[1].id, wlog[2].id);
            end
            checks++;
            if (wlog[1].cyc - wlog[0].cyc != 3 || wlog[2].cyc - wlog[1].cyc != 1) begin
                failures++;
                $display("FAIL drop_gap: gap1=%0d gap2=%0d required 3/1",
                         wlog[1].cyc - wlog[0].cyc, wlog[2].cyc - wlog[1].cyc);
            end
        end
    endtask

    task automatic test_reset_midburst();
        int n;
        do_reset();
        load(0, 'h41, 4);
        load(2, 'h61, 2);
        n = 0;
        while (wlog.size() < 1 && n < 20) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (s_we !== 1'b0 || s_ready !== '0) begin
            failures++;
            $display("FAIL rst_cycle_write: we=%b ready=%b required 0/0", s_we, s_ready);
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== '0 || fifo_we !== 1'b0 || req_ready !== '0 || fifo_wdata !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: busy=%b grant=%0d we=%b ready=%b wdata=%h required all 0",
                     busy, grant_id, fifo_we, req_ready, fifo_wdata);
        end
        n = 0;
        while (s_busy !== 1'b1 && n < 5) begin
            step();
            n++;
        end
        checks++;
        if (s_busy !== 1'b1 || s_grant !== '0) begin
            failures++;
            $display("FAIL rst_regrant: busy=%b grant=%0d required 1/0", s_busy, s_grant);
        end
        wait_drain(30, "rst");
        step();
        checks++;
        if (wlog.size() != 6 || wlog[1].id != 0 || wlog[1].data != 'h42 || wlog[5].id != 2) begin
            failures++;
            $display("FAIL rst_sequence: writes=%0d (6 required, second 0/42, last from 2)", wlog.size());
        end
    endtask

    task automatic test_random_e2e();
        int n;
        do_reset();
        use_model = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) load(k, k * 64, 16);
        n = 0;
        while (any_src() && n < 2000) begin
            for (int k = 0; k < NUM_REQ; k++) en[k] = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL e2e_timeout: words still pending after %0d cycles", n);
        end
        step();
        checks++;
        if (wlog.size() != 64) begin
            failures++;
            $display("FAIL e2e_count: writes=%0d required 64", wlog.size());
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                failures++;
                $display("FAIL e2e_missing%0d: %0d words never written", k, exp_q[k].size());
            end
        end
        use_model = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        clear_bench();
        @(posedge clk);
        #1;
        test_reset();
        test_single_stream();
        test_fairness();
        test_full_midburst();
        test_early_drop();
        test_reset_midburst();
        test_random_e2e();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
